// File: rtl/hilo_seq_ctrl.sv
// hilo_seq_ctrl -- sequencer between the control unit and the iterative
// mult/div units. Accepts one request, pulses the selected unit's start,
// waits its fixed latency with stall held high, captures the result into
// the architectural HI/LO registers, then pulses done.
//
// Optional feature, macro DIV0_EXC_EN: adds output div0_exc. A DIV with a
// zero divisor bypasses the divider, leaves HI/LO untouched and raises
// div0_exc together with done. Without the macro a zero divisor is
// sequenced like any other DIV.
module hilo_seq_ctrl #(
  parameter int unsigned MULT_LAT = 37,
  parameter int unsigned DIV_LAT  = 34,
  parameter int unsigned CNT_W    = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_div,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic        mult_start,
  output logic        div_start,
  output logic [31:0] unit_A,
  output logic [31:0] unit_B,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
`ifdef DIV0_EXC_EN
  output logic        div0_exc,
`endif
  output logic        done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CAPTURE = 2'd3;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q;
  logic [31:0]      unit_A_q, unit_B_q;
  logic [31:0]      hi_q, lo_q;
  logic             done_q;
  logic             accept;
`ifdef DIV0_EXC_EN
  logic             div0_q;
  logic             div0_exc_q;
  logic             div0_req;

  assign div0_req = op_div && (opB == '0);
`endif

  assign accept = (state_q == S_IDLE) && op_valid;

  // Next-state and latency counter logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
`ifdef DIV0_EXC_EN
          if (div0_req) state_d = S_CAPTURE;
          else          state_d = S_ISSUE;
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        cnt_d   = sel_q ? DIV_LOAD : MULT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_CAPTURE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand and unit-select capture on accept; held until the next accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unit_A_q <= '0;
      unit_B_q <= '0;
      sel_q    <= 1'b0;
    end else if (accept) begin
      unit_A_q <= opA;
      unit_B_q <= opB;
      sel_q    <= op_div;
    end
  end

`ifdef DIV0_EXC_EN
  // Remember whether the accepted request was a divide by zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div0_q <= 1'b0;
    end else if (accept) begin
      div0_q <= div0_req;
    end
  end

  // Exception flag pulses alongside done for a bypassed divide by zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div0_exc_q <= 1'b0;
    end else begin
      div0_exc_q <= (state_q == S_CAPTURE) && div0_q;
    end
  end

  assign div0_exc = div0_exc_q;
`endif

  // Architectural HI/LO update, only in CAPTURE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
`ifdef DIV0_EXC_EN
    end else if ((state_q == S_CAPTURE) && !div0_q) begin
`else
    end else if (state_q == S_CAPTURE) begin
`endif
      hi_q <= sel_q ? div_hi : mult_hi;
      lo_q <= sel_q ? div_lo : mult_lo;
    end
  end

  // Done pulse in the cycle after CAPTURE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= (state_q == S_CAPTURE);
    end
  end

  assign mult_start = (state_q == S_ISSUE) && !sel_q;
  assign div_start  = (state_q == S_ISSUE) && sel_q;
  assign stall      = (state_q != S_IDLE) || op_valid;
  assign unit_A     = unit_A_q;
  assign unit_B     = unit_B_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign done       = done_q;

endmodule

// File: tb/tb_hilo_seq_ctrl.sv
// Directed bench for hilo_seq_ctrl with behavioural mult/div unit stubs that
// only present a valid result once their latency has elapsed.
module tb_hilo_seq_ctrl;

  localparam int unsigned ML = 37;
  localparam int unsigned DL = 34;

  logic        clk = 1'b0;
  logic        reset, op_valid, op_div;
  logic [31:0] opA, opB;
  logic        mult_start, div_start, stall, done;
  logic [31:0] unit_A, unit_B, mult_hi, mult_lo, div_hi, div_lo, hi, lo;
`ifdef DIV0_EXC_EN
  logic        div0_exc;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hilo_seq_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_div(op_div),
    .opA(opA), .opB(opB), .mult_start(mult_start), .div_start(div_start),
    .unit_A(unit_A), .unit_B(unit_B), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .hi(hi), .lo(lo), .stall(stall),
`ifdef DIV0_EXC_EN
    .div0_exc(div0_exc),
`endif
    .done(done)
  );

  // Unit stubs: results are garbage until LAT cycles after the start edge
  int          mcnt = 0, dcnt = 0;
  logic [31:0] ma, mb, da, db;
  logic [63:0] mprod;
  always @(posedge clk) begin
    if (mult_start) begin
      mcnt <= 1; ma <= unit_A; mb <= unit_B;
    end else if (mcnt != 0 && mcnt < 1000) mcnt <= mcnt + 1;
    if (div_start) begin
      dcnt <= 1; da <= unit_A; db <= unit_B;
    end else if (dcnt != 0 && dcnt < 1000) dcnt <= dcnt + 1;
  end
  always_comb begin
    mprod   = 64'($signed(ma)) * 64'($signed(mb));
    mult_hi = 32'hDEADBEEF;
    mult_lo = 32'hDEADBEEF;
    div_hi  = 32'hBADC0DE0;
    div_lo  = 32'hBADC0DE0;
    if (mcnt > int'(ML)) begin
      mult_hi = mprod[63:32];
      mult_lo = mprod[31:0];
    end
    if (dcnt > int'(DL)) begin
      if (db == 32'd0) begin
        div_hi = da;
        div_lo = 32'hFFFFFFFF;
      end else begin
        div_hi = 32'($signed(da) % $signed(db));
        div_lo = 32'($signed(da) / $signed(db));
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request, check combinational stall, return #1 after accept edge
  task automatic accept(input logic d, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op_div = d; opA = a; opB = b;
    #1;
    check("stall_in_accept_cycle", 64'(stall), 64'd1);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  // Run one operation from accept to done and check timing and results
  task automatic run(input string tag, input logic d, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_hi,
                     input logic [31:0] exp_lo, input int unsigned lat,
                     input bit poke, input bit b2b);
    logic [31:0] old_hi, old_lo;
    int ms, ds, st, k;
    bit seen;
    old_hi = hi; old_lo = lo;
    ms = 0; ds = 0; st = 0; k = 0; seen = 0;
    accept(d, a, b);
    // operands and op type change after accept must have no effect
    opA = 32'hA5A5A5A5; opB = 32'h00000001; op_div = ~d;
    while (!seen && k < 80) begin
      if (mult_start) ms++;
      if (div_start)  ds++;
      if (stall)      st++;
      if (k == int'(lat) + 1) begin
        check({tag, "_hi_held_in_capture"}, 64'(hi), 64'(old_hi));
        check({tag, "_lo_held_in_capture"}, 64'(lo), 64'(old_lo));
      end
      if (poke && k == 5) op_valid = 1'b1;
      if (poke && k == 6) op_valid = 1'b0;
      if (done) seen = 1;
      else begin
        @(posedge clk); #1; k++;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_done_edge"}, 64'(k), 64'(lat + 2));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    check({tag, "_mult_starts"}, 64'(ms), d ? 64'd0 : 64'd1);
    check({tag, "_div_starts"}, 64'(ds), d ? 64'd1 : 64'd0);
    check({tag, "_stall_cycles"}, 64'(st), 64'(lat + 2));
    check({tag, "_stall_low_in_done"}, 64'(stall), 64'd0);
    check({tag, "_unit_A_held"}, 64'(unit_A), 64'(a));
    check({tag, "_unit_B_held"}, 64'(unit_B), 64'(b));
    if (!b2b) begin
      @(posedge clk); #1;
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    int dn, st;
    reset = 1'b1; op_valid = 1'b0; op_div = 1'b0; opA = '0; opB = '0;
    #2 reset = 1'b0;
    #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_units", {unit_A, unit_B}, 64'd0);
    check("rst_ctl", {60'd0, stall, done, mult_start, div_start}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // MULT 7 * -3 = -21
    run("mult", 1'b0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, ML, 1'b0, 1'b0);
    // DIV 100 / 7: quotient 14, remainder 2
    run("div", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, DL, 1'b0, 1'b0);
    // MULT with an intruding DIV request during WAIT, then back-to-back DIV
    run("mult_poke", 1'b0, 32'h00010000, 32'h00030000, 32'h00000003, 32'h00000000, ML, 1'b1, 1'b1);
    run("div_b2b", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, DL, 1'b0, 1'b0);

    // Reset in the middle of WAIT
    accept(1'b0, 32'd3, 32'd5);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    dn = 0; st = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (done) dn++;
      if (stall || mult_start) st++;
    end
    check("midrst_no_done", 64'(dn), 64'd0);
    check("midrst_idle", 64'(st), 64'd0);

`ifdef DIV0_EXC_EN
    run("mult_pre0", 1'b0, 32'd6, 32'd9, 32'd0, 32'd54, ML, 1'b0, 1'b0);
    accept(1'b1, 32'd55, 32'd0);
    check("div0_stall_plus_one", 64'(stall), 64'd1);
    check("div0_no_start", {62'd0, div_start, mult_start}, 64'd0);
    @(posedge clk); #1;
    check("div0_done", 64'(done), 64'd1);
    check("div0_exc", 64'(div0_exc), 64'd1);
    check("div0_stall_low", 64'(stall), 64'd0);
    check("div0_hilo_kept", {hi, lo}, {32'd0, 32'd54});
    @(posedge clk); #1;
    check("div0_exc_one_cycle", {62'd0, div0_exc, done}, 64'd0);
`else
    // Divide by zero runs a normal DIV; stub returns hi=dividend, lo=all ones
    run("div0", 1'b1, 32'd55, 32'd0, 32'd55, 32'hFFFFFFFF, DL, 1'b0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
